dual_port_ram_be: RTL

Parametrised true dual-port RAM, successor to the current 64×512 dual-port buffer used by the row-processing datapath. It adds per-byte write enables, explicit read enables with a valid strobe, selectable same-port read-during-write behaviour, an optional output pipeline register, deterministic write-write collision resolution with a collision flag, and a hardware clear engine that sweeps the whole array to a constant. Memory contents survive reset. Only control and output state is reset.

---
 rtl/dual_port_ram_be.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_be.sv
// True dual-port byte-enable RAM with read-valid strobes, A-wins write collisions and a sweep-clear engine.
// Read data valid two edges after the request edge (three with OUT_REG); no backpressure, port requests dropped while busy.
module dual_port_ram_be #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    ADDR_WIDTH  = 9,
  parameter int                    BYTE_WIDTH  = 8,
  parameter bit                    RDW_MODE    = 1'b0,
  parameter bit                    OUT_REG     = 1'b0,
  parameter                        INIT_FILE   = "",
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            address_a,
  input  logic [ADDR_WIDTH-1:0]            address_b,
  input  logic [DATA_WIDTH-1:0]            data_a,
  input  logic [DATA_WIDTH-1:0]            data_b,
  input  logic                             wren_a,
  input  logic                             wren_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic                             rden_a,
  input  logic                             rden_b,
  output logic [DATA_WIDTH-1:0]            q_a,
  output logic [DATA_WIDTH-1:0]            q_b,
  output logic                             qvalid_a,
  output logic                             qvalid_b,
  input  logic                             clear_start,
  output logic                             busy,
  output logic                             collision
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    coll_q, coll_d;
  logic [1:0]              v1_q, v1_d, v2_q, v2_d;
  logic [DATA_WIDTH-1:0]   d1_q [2];
  logic [DATA_WIDTH-1:0]   d1_d [2];
  logic [DATA_WIDTH-1:0]   d2_q [2];
  logic [DATA_WIDTH-1:0]   d2_d [2];
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc, we_a, we_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0]   rdat_a, rdat_b;

  assign acc  = (state_q == ST_IDLE);
  assign we_a = wren_a & acc;
  assign we_b = wren_b & acc;
  assign rd_a = rden_a & acc;
  assign rd_b = rden_b & acc;

  // Read data is captured at the request edge, so a write on that same edge never leaks into it
  // unless RDW_MODE asks for the merged word on the writing port.
  always_comb begin
    rdat_a = mem[address_a];
    rdat_b = mem[address_b];
    if (RDW_MODE) begin
      for (int i = 0; i < NB; i++) begin
        if (we_a && be_a[i]) rdat_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (we_b && be_b[i]) rdat_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Port A's byte writes come last so it wins overlapping lanes on a shared address.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (we_b && be_b[i]) mem[address_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (we_a && be_a[i]) mem[address_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: if (clear_start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    coll_d = we_a & we_b & (address_a == address_b) & (|(be_a & be_b));
  end

  always_comb begin
    v1_d    = {rd_b, rd_a};
    d1_d[0] = rd_a ? rdat_a : d1_q[0];
    d1_d[1] = rd_b ? rdat_b : d1_q[1];
    v2_d    = v1_q;
    for (int p = 0; p < 2; p++) d2_d[p] = v1_q[p] ? d1_q[p] : d2_q[p];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      coll_q  <= 1'b0;
      v1_q    <= '0;
      v2_q    <= '0;
      d1_q    <= '{default: '0};
      d2_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      coll_q  <= coll_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [1:0]            v3_q, v3_d;
    logic [DATA_WIDTH-1:0] d3_q [2];
    logic [DATA_WIDTH-1:0] d3_d [2];

    always_comb begin
      v3_d = v2_q;
      for (int p = 0; p < 2; p++) d3_d[p] = v2_q[p] ? d2_q[p] : d3_q[p];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v3_q <= '0;
        d3_q <= '{default: '0};
      end else begin
        v3_q <= v3_d;
        d3_q <= d3_d;
      end
    end

    assign q_a      = d3_q[0];
    assign q_b      = d3_q[1];
    assign qvalid_a = v3_q[0];
    assign qvalid_b = v3_q[1];
  end else begin : g_no_out_reg
    assign q_a      = d2_q[0];
    assign q_b      = d2_q[1];
    assign qvalid_a = v2_q[0];
    assign qvalid_b = v2_q[1];
  end

  assign busy      = (state_q == ST_CLEAR);
  assign collision = coll_q;
endmodule
